mips_cpu_sequencer: RTL and testbench

Multi-cycle state sequencer for the MIPS CPU core. It generates the 3-bit State code and the Verify qualifier consumed by the control decoder, and stalls on Avalon memory waitrequest and on multiply/divide completion. It also pulses the IR and PC update enables, detects CPU halt (jump to address 0) and keeps retired-instruction and cycle counters.

---
 rtl/mips_cpu_sequencer.sv | 102 ++++++++++
 tb/tb_mips_cpu_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle state sequencer for the MIPS core: produces State/Verify for the
// control decoder, stalls on memory and muldiv, detects halt, keeps perf counters.
module mips_cpu_sequencer #(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned MULDIV_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 waitrequest,
  input  logic                 mem_access,
  input  logic                 muldiv_op,
  input  logic                 muldiv_done,
  input  logic                 pc_next_zero,
  output logic [2:0]           State,
  output logic                 Verify,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int unsigned TW      = (MULDIV_TIMEOUT > 2) ? $clog2(MULDIV_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (MULDIV_TIMEOUT > 0) ? MULDIV_TIMEOUT - 1 : 0;
  localparam bit          TO_EN   = (MULDIV_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t        st;
  logic [TW-1:0] tcnt;
  logic          exec_hold;

  assign State = st;
  assign ir_en = (st == S_FETCH) && !waitrequest;
  assign pc_en = (st == S_WB);

  // The timeout only bounds a muldiv that never reports done.
  assign exec_hold = muldiv_op && !muldiv_done && !(TO_EN && (tcnt == TW'(TO_LAST)));

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_IDLE;
      Verify      <= 1'b0;
      active      <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
      tcnt        <= '0;
    end else begin
      if (active) cycle_count <= cycle_count + CNT_WIDTH'(1);
      case (st)
        S_IDLE: begin
          st     <= S_FETCH;
          active <= 1'b1;
          Verify <= 1'b0;
        end
        S_FETCH: begin
          Verify <= 1'b0;
          if (!waitrequest) begin
            st     <= S_DECODE;
            Verify <= 1'b1;
          end
        end
        S_DECODE: st <= S_EXEC;
        S_EXEC: begin
          if (exec_hold) begin
            tcnt <= tcnt + TW'(1);
          end else begin
            tcnt <= '0;
            st   <= S_MEM;
          end
        end
        S_MEM: if (!(mem_access && waitrequest)) st <= S_WB;
        S_WB: begin
          instr_count <= instr_count + CNT_WIDTH'(1);
          if (pc_next_zero) begin
            st     <= S_HALT;
            active <= 1'b0;
          end else begin
            st     <= S_FETCH;
            Verify <= 1'b0;
          end
        end
        S_HALT: active <= 1'b0;
        default: begin
          st     <= S_IDLE;
          active <= 1'b0;
          Verify <= 1'b0;
          tcnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Bench for mips_cpu_sequencer: instructions described as stall lengths expand
// into an expected per-cycle trace; two instances cover default and short timeout.
module tb_mips_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        wr  [2];
  logic        ma  [2];
  logic        mo  [2];
  logic        md  [2];
  logic        pz  [2];
  logic [2:0]  st_o  [2];
  logic        ver_o [2];
  logic        ir_o  [2];
  logic        pc_o  [2];
  logic        act_o [2];
  logic [31:0] cc0, ic0;
  logic [7:0]  cc1, ic1;

  int unsigned tmo   [2] = '{64, 4};
  int unsigned cmask [2] = '{32'hffff_ffff, 32'h0000_00ff};
  int unsigned exp_cc [2];
  int unsigned exp_ic [2];
  int vectors     = 0;
  int miscompares = 0;

  mips_cpu_sequencer u_dut0 (
    .clk(clk), .reset(rst[0]), .waitrequest(wr[0]), .mem_access(ma[0]),
    .muldiv_op(mo[0]), .muldiv_done(md[0]), .pc_next_zero(pz[0]),
    .State(st_o[0]), .Verify(ver_o[0]), .ir_en(ir_o[0]), .pc_en(pc_o[0]),
    .active(act_o[0]), .cycle_count(cc0), .instr_count(ic0)
  );

  mips_cpu_sequencer #(.CNT_WIDTH(8), .MULDIV_TIMEOUT(4)) u_dut1 (
    .clk(clk), .reset(rst[1]), .waitrequest(wr[1]), .mem_access(ma[1]),
    .muldiv_op(mo[1]), .muldiv_done(md[1]), .pc_next_zero(pz[1]),
    .State(st_o[1]), .Verify(ver_o[1]), .ir_en(ir_o[1]), .pc_en(pc_o[1]),
    .active(act_o[1]), .cycle_count(cc1), .instr_count(ic1)
  );

  function automatic logic [31:0] get_cc(input int s);
    return (s == 0) ? cc0 : {24'h0, cc1};
  endfunction

  function automatic logic [31:0] get_ic(input int s);
    return (s == 0) ? ic0 : {24'h0, ic1};
  endfunction

  task automatic rand_in(input int s);
    wr[s] = 1'($urandom);
    ma[s] = 1'($urandom);
    mo[s] = 1'($urandom);
    md[s] = 1'($urandom);
    pz[s] = 1'($urandom);
  endtask

  // Compare one cycle against expectations, then advance and update counters.
  task automatic chk(input int s, input string tag, input int e_st,
                     input bit e_ver, input bit e_ir, input bit e_pc, input bit e_act);
    logic [31:0] e_cc, e_ic;
    #1;
    e_cc = exp_cc[s] & cmask[s];
    e_ic = exp_ic[s] & cmask[s];
    vectors++;
    assert (st_o[s] === 3'(e_st)) else begin
      miscompares++; $error("FAIL %s[%0d] State obs=%0d exp=%0d", tag, s, st_o[s], e_st); end
    assert (ver_o[s] === e_ver) else begin
      miscompares++; $error("FAIL %s[%0d] Verify obs=%b exp=%b", tag, s, ver_o[s], e_ver); end
    assert (ir_o[s] === e_ir) else begin
      miscompares++; $error("FAIL %s[%0d] ir_en obs=%b exp=%b", tag, s, ir_o[s], e_ir); end
    assert (pc_o[s] === e_pc) else begin
      miscompares++; $error("FAIL %s[%0d] pc_en obs=%b exp=%b", tag, s, pc_o[s], e_pc); end
    assert (act_o[s] === e_act) else begin
      miscompares++; $error("FAIL %s[%0d] active obs=%b exp=%b", tag, s, act_o[s], e_act); end
    assert (get_cc(s) === e_cc) else begin
      miscompares++; $error("FAIL %s[%0d] cycle_count obs=%0d exp=%0d", tag, s, get_cc(s), e_cc); end
    assert (get_ic(s) === e_ic) else begin
      miscompares++; $error("FAIL %s[%0d] instr_count obs=%0d exp=%0d", tag, s, get_ic(s), e_ic); end
    @(posedge clk);
    #1;
    if (e_act) exp_cc[s]++;
    if (e_pc)  exp_ic[s]++;
  endtask

  task automatic do_reset(input int s, input int n);
    rst[s] = 1'b1;
    rand_in(s);
    @(posedge clk);
    #1;
    exp_cc[s] = 0;
    exp_ic[s] = 0;
    for (int i = 1; i < n; i++) begin
      rand_in(s);
      chk(s, "reset", 0, 0, 0, 0, 0);
    end
    rst[s] = 1'b0;
    rand_in(s);
    chk(s, "idle", 0, 0, 0, 0, 0);
  endtask

  // One instruction: f fetch waits, optional muldiv with done at EXEC cycle d,
  // optional memory access with w waits, halt flag; abort_mem>=0 stops mid-MEM.
  task automatic run_instr(input int s, input int f, input bit op, input int d,
                           input bit mem, input int w, input bit pzv,
                           input int abort_mem, output bit halted);
    int lim, xl, ml;
    halted = 1'b0;
    for (int i = 0; i <= f; i++) begin
      rand_in(s);
      wr[s] = 1'(i < f);
      chk(s, "fetch", 1, 0, (i == f), 0, 1);
    end
    rand_in(s);
    chk(s, "decode", 2, 1, 0, 0, 1);
    lim = (tmo[s] > 0) ? int'(tmo[s]) - 1 : 32'h3fff_ffff;
    xl  = op ? (((d < lim) ? d : lim) + 1) : 1;
    for (int i = 0; i < xl; i++) begin
      rand_in(s);
      mo[s] = op;
      if (op) md[s] = 1'(i >= d);
      chk(s, "exec", 3, 1, 0, 0, 1);
    end
    ml = mem ? w + 1 : 1;
    for (int i = 0; i < ml; i++) begin
      rand_in(s);
      ma[s] = mem;
      if (mem) wr[s] = 1'(i < w);
      if (i == abort_mem) return;
      chk(s, "mem", 4, 1, 0, 0, 1);
    end
    rand_in(s);
    pz[s] = pzv;
    chk(s, "wb", 5, 1, 0, 1, 1);
    if (pzv) begin
      halted = 1'b1;
      repeat (10) begin
        rand_in(s);
        chk(s, "halt", 6, 1, 0, 0, 0);
      end
    end
  endtask

  initial begin
    bit h;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; wr[s] = 1'b0; ma[s] = 1'b0; mo[s] = 1'b0; md[s] = 1'b0; pz[s] = 1'b0;
      exp_cc[s] = 0; exp_ic[s] = 0;
    end

    // Directed scenarios on the default-parameter instance
    do_reset(0, 3);
    run_instr(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, -1, h);
    run_instr(0, 4, 1'b0, 0, 1'b0, 0, 1'b0, -1, h);
    run_instr(0, 0, 1'b0, 0, 1'b1, 2, 1'b0, -1, h);
    run_instr(0, 1, 1'b1, 7, 1'b0, 0, 1'b0, -1, h);
    run_instr(0, 0, 1'b0, 0, 1'b1, 0, 1'b1, -1, h);
    do_reset(0, 1);
    run_instr(0, 2, 1'b0, 0, 1'b1, 5, 1'b0, 2, h);
    do_reset(0, 2);

    // Randomized instruction streams on both instances
    for (int s = 0; s < 2; s++) begin
      if (s == 1) begin
        rst[0] = 1'b1;
        do_reset(1, 2);
        run_instr(1, 0, 1'b1, 1000, 1'b0, 0, 1'b0, -1, h);
        run_instr(1, 0, 1'b1, 2, 1'b1, 1, 1'b0, -1, h);
      end
      for (int n = 0; n < 60; n++) begin
        int  f, d, w;
        bit  op, mem, pzv;
        f   = $urandom_range(0, 3);
        op  = ($urandom_range(0, 2) == 0);
        d   = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(0, 9));
        mem = 1'($urandom);
        w   = $urandom_range(0, 3);
        pzv = ($urandom_range(0, 24) == 0);
        run_instr(s, f, op, d, mem, w, pzv, -1, h);
        if (h) do_reset(s, $urandom_range(1, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
